// File: rtl/mem_to_reg_loader.sv
// Burst loader: reads consecutive words from a fixed-latency memory and writes them
// into consecutive destination registers, one READ/WAIT/WRITE round per word.
module mem_to_reg_loader #(
    parameter int WIDTH       = 12,
    parameter int ADDR_WIDTH  = 8,
    parameter int REG_SEL_W   = 3,
    parameter int LEN_WIDTH   = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [REG_SEL_W-1:0]  baseReg,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRdEn,
    input  logic [WIDTH-1:0]      memData,
    output logic [REG_SEL_W-1:0]  regSel,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  wrEn,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_SEL_W-1:0]  reg_q, reg_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [REG_SEL_W-1:0]  reg_sel_q, reg_sel_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Outputs are registered: each strobe is computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        remain_d    = remain_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        reg_sel_d   = reg_sel_q;
        data_out_d  = data_out_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = baseAddr;
                    reg_d    = baseReg;
                    remain_d = length;
                    if (length != '0) begin
                        state_d     = READ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = baseAddr;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LATENCY - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d    = WRITE;
                    data_out_d = memData;
                    reg_sel_d  = reg_q;
                    wr_en_d    = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            WRITE: begin
                addr_d   = addr_q + 1'b1;
                reg_d    = reg_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (remain_q == LEN_WIDTH'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = READ;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = addr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reg_q       <= '0;
            remain_q    <= '0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            reg_sel_q   <= '0;
            data_out_q  <= '0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            remain_q    <= remain_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            reg_sel_q   <= reg_sel_d;
            data_out_q  <= data_out_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign memAddr   = mem_addr_q;
    assign memRdEn   = mem_rd_en_q;
    assign regSel    = reg_sel_q;
    assign dataOut   = data_out_q;
    assign wrEn      = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
